// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like request arbiter: arbiter state
// encoding, master IDs and transfer size encodings.
package sram_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam logic MID_INST = 1'b0;
    localparam logic MID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response channel bundle.
//
// Handshake: a request is held stable by the master while req=1 and is
// transferred in the cycle where req=1 and addr_ok=1. data_ok is a
// one-cycle pulse per accepted request, returned in acceptance order;
// rdata is meaningful only while data_ok=1. There is no back-pressure
// on the response side.
interface sram_req_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_arb_ord_fifo.sv
// Ordering FIFO holding the 1-bit owner ID of each accepted request.
// Pointers wrap naturally because DEPTH is a power of two.
module sram_arb_ord_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Owner storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// 2:1 arbiter sharing one SRAM-like slave port between the instruction
// master (m0) and the data master (m1). Responses are routed back to
// their owner in acceptance order via an ordering FIFO.
// Optional macro SRAM_ARB_RR_EN: round-robin grant instead of fixed
// m1-over-m0 priority.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    sram_req_arbiter_if.slave     m0,
    sram_req_arbiter_if.slave     m1,
    sram_req_arbiter_if.master    s,
    output logic [CNT_W-1:0]      outst_cnt,
    output logic                  resp_err,
    output arb_state_t            dbg_state
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       gnt_r;
    logic       gnt_r_nxt;
    logic       grant;
    logic       pick;
    logic       s_req_c;
    logic       full;
    logic       empty;
    logic       head;
    logic       push;
    logic       pop;

`ifdef SRAM_ARB_RR_EN
    logic rr_last;

    // Round-robin pick: on contention favour the master not served last.
    always_comb begin
        pick = m1.req ? MID_DATA : MID_INST;
        if (m0.req && m1.req) pick = ~rr_last;
    end

    // Remember the owner of the most recently accepted request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  rr_last <= 1'b0;
        else if (push) rr_last <= grant;
    end
`else
    // Fixed priority pick: data master wins over instruction master.
    always_comb begin
        pick = m1.req ? MID_DATA : MID_INST;
    end
`endif

    // Grant selection, slave request and next-state; lock holds the grant
    // stable from request assertion until the slave accepts it.
    always_comb begin
        state_nxt = state;
        gnt_r_nxt = gnt_r;
        grant     = pick;
        s_req_c   = 1'b0;
        case (state)
            ARB_IDLE: grant = pick;
            ARB_LOCK: grant = gnt_r;
            default:  grant = pick;
        endcase
        s_req_c = (grant ? m1.req : m0.req) & ~full & aresetn;
        case (state)
            ARB_IDLE: begin
                if (s_req_c && !s.addr_ok) begin
                    state_nxt = ARB_LOCK;
                    gnt_r_nxt = grant;
                end
            end
            ARB_LOCK: begin
                if (s.addr_ok) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Arbiter state and locked grant registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ARB_IDLE;
            gnt_r <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt_r <= gnt_r_nxt;
        end
    end

    assign dbg_state = state;

    assign s.req   = s_req_c;
    assign s.wr    = grant ? m1.wr    : m0.wr;
    assign s.size  = grant ? m1.size  : m0.size;
    assign s.addr  = grant ? m1.addr  : m0.addr;
    assign s.wstrb = grant ? m1.wstrb : m0.wstrb;
    assign s.wdata = grant ? m1.wdata : m0.wdata;

    assign m0.addr_ok = s.addr_ok & s_req_c & (grant == MID_INST);
    assign m1.addr_ok = s.addr_ok & s_req_c & (grant == MID_DATA);

    assign push = s_req_c & s.addr_ok;
    assign pop  = s.data_ok & ~empty;

    // Responses go to the FIFO head owner in the same cycle.
    assign m0.data_ok = pop & (head == MID_INST);
    assign m1.data_ok = pop & (head == MID_DATA);
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;

    sram_arb_ord_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_ord_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push    (push),
        .push_id (grant),
        .pop     (pop),
        .head    (head),
        .count   (outst_cnt),
        .full    (full),
        .empty   (empty)
    );

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                resp_err <= 1'b0;
        else if (s.data_ok && empty) resp_err <= 1'b1;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed vectors, response
// scoreboard with an expected queue checked by an independent monitor.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int MAX_OUTST = 4;
    localparam int CNT_W     = $clog2(MAX_OUTST) + 1;

    logic             aclk;
    logic             aresetn;
    logic [CNT_W-1:0] outst_cnt;
    logic             resp_err;
    arb_state_t       dbg_state;

    sram_req_arbiter_if m0_if ();
    sram_req_arbiter_if m1_if ();
    sram_req_arbiter_if s_if ();

    int total = 0;
    int bad   = 0;

    // Expected responses: {owner id, rdata}
    logic [32:0] exp_q[$];

    sram_req_arbiter #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .outst_cnt (outst_cnt),
        .resp_err  (resp_err),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.req = 1'b0; m0_if.wr = 1'b0; m0_if.size = SIZE_WORD;
        m0_if.addr = 32'h0; m0_if.wstrb = 4'h0; m0_if.wdata = 32'h0;
        m1_if.req = 1'b0; m1_if.wr = 1'b0; m1_if.size = SIZE_WORD;
        m1_if.addr = 32'h0; m1_if.wstrb = 4'h0; m1_if.wdata = 32'h0;
        s_if.addr_ok = 1'b0; s_if.data_ok = 1'b0; s_if.rdata = 32'h0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    // One response cycle; expected owner is pushed before the DUT shows it
    task automatic resp(input logic id, input logic [31:0] data);
        s_if.data_ok = 1'b1;
        s_if.rdata   = data;
        exp_q.push_back({id, data});
        step();
        s_if.data_ok = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge aclk) begin
        logic [32:0] exp_v;
        logic [32:0] act_v;
        if (aresetn && (m0_if.data_ok || m1_if.data_ok)) begin
            total++;
            if (m0_if.data_ok && m1_if.data_ok) begin
                bad++;
                $display("FAIL both_data_ok: got=11 expected=one-hot");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_data_ok: got m0=%b m1=%b expected none", m0_if.data_ok, m1_if.data_ok);
            end else begin
                exp_v = exp_q.pop_front();
                act_v = m1_if.data_ok ? {1'b1, m1_if.rdata} : {1'b0, m0_if.rdata};
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL resp_route: got id=%0d data=%h expected id=%0d data=%h",
                             act_v[32], act_v[31:0], exp_v[32], exp_v[31:0]);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        aresetn = 1'b0;
        m0_if.req = 1'b1;
        m1_if.req = 1'b1;
        s_if.addr_ok = 1'b1;
        s_if.data_ok = 1'b1;
        @(negedge aclk);
        chk("rst_s_req", 32'(s_if.req), 32'd0);
        chk("rst_m0_addr_ok", 32'(m0_if.addr_ok), 32'd0);
        chk("rst_m1_data_ok", 32'(m1_if.data_ok | m0_if.data_ok), 32'd0);
        chk("rst_cnt", 32'(outst_cnt), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        idle_inputs();
        do_reset();

        // Both masters request, slave always ready: m1 first, then m0
        m0_if.req = 1'b1; m0_if.addr = 32'h0000_0100;
        m1_if.req = 1'b1; m1_if.addr = 32'h0000_0200;
        s_if.addr_ok = 1'b1;
        @(negedge aclk);
        chk("pri_m1_addr_ok", 32'(m1_if.addr_ok), 32'd1);
        chk("pri_m0_addr_ok", 32'(m0_if.addr_ok), 32'd0);
        chk("pri_s_addr", s_if.addr, 32'h0000_0200);
        step();
        m1_if.req = 1'b0;
        @(negedge aclk);
        chk("pri2_m0_addr_ok", 32'(m0_if.addr_ok), 32'd1);
        chk("pri2_s_addr", s_if.addr, 32'h0000_0100);
        step();
        idle_inputs();
        @(negedge aclk);
        chk("pri_cnt", 32'(outst_cnt), 32'd2);
        step();
        resp(1'b1, 32'h0000_00A1);
        resp(1'b0, 32'h0000_00A2);
        @(negedge aclk);
        chk("pri_drain_cnt", 32'(outst_cnt), 32'd0);

        // Lock: m0 waits three cycles, m1 arrives meanwhile
        m0_if.req = 1'b1; m0_if.addr = 32'h0000_0300; m0_if.wr = 1'b1;
        m0_if.wdata = 32'hDEAD_BEEF; m0_if.wstrb = 4'hF;
        @(negedge aclk);
        chk("lk_t0_s_addr", s_if.addr, 32'h0000_0300);
        chk("lk_t0_s_req", 32'(s_if.req), 32'd1);
        step();
        m1_if.req = 1'b1; m1_if.addr = 32'h0000_0400;
        @(negedge aclk);
        chk("lk_t1_s_addr", s_if.addr, 32'h0000_0300);
        chk("lk_t1_state", 32'(dbg_state), 32'(ARB_LOCK));
        chk("lk_t1_s_wdata", s_if.wdata, 32'hDEAD_BEEF);
        step();
        @(negedge aclk);
        chk("lk_t2_s_addr", s_if.addr, 32'h0000_0300);
        chk("lk_t2_m1_addr_ok", 32'(m1_if.addr_ok), 32'd0);
        step();
        s_if.addr_ok = 1'b1;
        @(negedge aclk);
        chk("lk_t3_m0_addr_ok", 32'(m0_if.addr_ok), 32'd1);
        chk("lk_t3_s_addr", s_if.addr, 32'h0000_0300);
        step();
        m0_if.req = 1'b0;
        @(negedge aclk);
        chk("lk_t4_m1_addr_ok", 32'(m1_if.addr_ok), 32'd1);
        chk("lk_t4_s_addr", s_if.addr, 32'h0000_0400);
        step();
        idle_inputs();
        resp(1'b0, 32'h0000_00B1);
        resp(1'b1, 32'h0000_00B2);

        // Fill to MAX_OUTST, then pop/push interplay at the full boundary
        m0_if.req = 1'b1; m0_if.addr = 32'h0000_0500;
        s_if.addr_ok = 1'b1;
        for (int i = 0; i < MAX_OUTST; i++) step();
        @(negedge aclk);
        chk("full_cnt", 32'(outst_cnt), 32'(MAX_OUTST));
        chk("full_s_req", 32'(s_if.req), 32'd0);
        chk("full_m0_addr_ok", 32'(m0_if.addr_ok), 32'd0);
        resp(1'b0, 32'h0000_00C1);
        @(negedge aclk);
        chk("after_pop_cnt", 32'(outst_cnt), 32'(MAX_OUTST - 1));
        chk("after_pop_s_req", 32'(s_if.req), 32'd1);
        resp(1'b0, 32'h0000_00C2);
        @(negedge aclk);
        chk("push_pop_cnt", 32'(outst_cnt), 32'(MAX_OUTST - 1));
        step();
        m0_if.req = 1'b0;
        s_if.addr_ok = 1'b0;
        @(negedge aclk);
        chk("refull_cnt", 32'(outst_cnt), 32'(MAX_OUTST));
        resp(1'b0, 32'h0000_00C3);
        resp(1'b0, 32'h0000_00C4);
        resp(1'b0, 32'h0000_00C5);
        resp(1'b0, 32'h0000_00C6);
        @(negedge aclk);
        chk("full_drain_cnt", 32'(outst_cnt), 32'd0);

        // Response ordering: accept m0, m1, m0
        s_if.addr_ok = 1'b1;
        m0_if.req = 1'b1; m0_if.addr = 32'h0000_0600;
        step();
        m0_if.req = 1'b0;
        m1_if.req = 1'b1; m1_if.addr = 32'h0000_0700;
        step();
        m1_if.req = 1'b0;
        m0_if.req = 1'b1; m0_if.addr = 32'h0000_0800;
        step();
        idle_inputs();
        resp(1'b0, 32'h0000_0011);
        resp(1'b1, 32'h0000_0022);
        resp(1'b0, 32'h0000_0033);

        // Stray response with empty FIFO
        s_if.data_ok = 1'b1; s_if.rdata = 32'h0000_00EE;
        @(negedge aclk);
        chk("stray_data_ok", 32'({m1_if.data_ok, m0_if.data_ok}), 32'd0);
        step();
        idle_inputs();
        step();
        @(negedge aclk);
        chk("stray_err", 32'(resp_err), 32'd1);
        step();
        @(negedge aclk);
        chk("stray_err_sticky", 32'(resp_err), 32'd1);

        // Reset in the middle of a burst
        m0_if.req = 1'b1; s_if.addr_ok = 1'b1;
        step();
        step();
        aresetn = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(outst_cnt), 32'd0);
        chk("mid_rst_err", 32'(resp_err), 32'd0);
        chk("mid_rst_s_req", 32'(s_if.req), 32'd0);
        idle_inputs();
        step();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_cnt", 32'(outst_cnt), 32'd0);

`ifdef SRAM_ARB_RR_EN
        // Round-robin: constant contention alternates 1,0,1,0
        do_reset();
        m0_if.req = 1'b1; m1_if.req = 1'b1; s_if.addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("rr_m1_addr_ok", 32'(m1_if.addr_ok), 32'((i % 2) == 0));
            chk("rr_m0_addr_ok", 32'(m0_if.addr_ok), 32'((i % 2) == 1));
            step();
        end
        idle_inputs();
        resp(1'b1, 32'h0000_0D01);
        resp(1'b0, 32'h0000_0D02);
        resp(1'b1, 32'h0000_0D03);
        resp(1'b0, 32'h0000_0D04);
`endif

        step();
        step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
